// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/loader port and the shared data RAM.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 5
);
    logic          p_req;
    logic          p_we;
    logic [31:0]   p_addr;
    logic [31:0]   p_wdata;
    logic          p_stall;
    logic [31:0]   p_rdata;

    logic          d_req;
    logic          d_we;
    logic [31:0]   d_base;
    logic [3:0]    d_len;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic          d_done;

    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_stall, p_rdata,
        input  d_req, d_we, d_base, d_len, d_wdata,
        output d_ack, d_rdata, d_done,
        output m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_stall, p_rdata,
        output d_req, d_we, d_base, d_len, d_wdata,
        input  d_ack, d_rdata, d_done,
        input  m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the pipeline (zero latency, default owner)
// and fixed-length DMA bursts, with a starvation counter that forces DMA through.
module dmem_arbiter #(
    parameter int unsigned AW         = 5,
    parameter int unsigned BURST_MAX  = 8,
    parameter int unsigned STARVE_LIM = 4
) (
    input logic           clk,
    input logic           clrn,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] BurstMax  = 4'(BURST_MAX);
    localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

    typedef enum logic {StIdle, StDma} state_e;

    state_e        state_q, state_d;
    logic [3:0]    beat_q, beat_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    starve_q, starve_d;
    logic [AW-1:0] base_q, base_d;
    logic          we_q, we_d;

    logic [3:0]    len_eff;
    logic [AW-1:0] p_word;
    logic [AW-1:0] dma_word;
    logic          grant;
    logic          unused_bits;

    assign p_word   = bus.p_addr[AW+1:2];
    // Natural AW-bit overflow gives the wrap at the top of RAM.
    assign dma_word = base_q + AW'(beat_q);
    assign grant    = bus.d_req && (!bus.p_req || starve_q == StarveLim);
    assign unused_bits = ^{bus.p_addr[31:AW+2], bus.p_addr[1:0],
                           bus.d_base[31:AW+2], bus.d_base[1:0]};

    always_comb begin
        len_eff = bus.d_len;
        if (bus.d_len == 4'd0) begin
            len_eff = 4'd1;
        end else if (bus.d_len > BurstMax) begin
            len_eff = BurstMax;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        len_d    = len_q;
        starve_d = starve_q;
        base_d   = base_q;
        we_d     = we_q;

        bus.m_addr  = p_word;
        bus.m_we    = bus.p_req & bus.p_we;
        bus.m_wdata = bus.p_wdata;
        bus.p_rdata = bus.m_rdata;
        bus.d_rdata = bus.m_rdata;
        bus.p_stall = 1'b0;
        bus.d_ack   = 1'b0;
        bus.d_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d  = StDma;
                    base_d   = bus.d_base[AW+1:2];
                    len_d    = len_eff;
                    we_d     = bus.d_we;
                    beat_d   = 4'd0;
                    starve_d = 4'd0;
                end else if (bus.d_req && bus.p_req) begin
                    if (starve_q != 4'hF) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (!bus.d_req) begin
                    starve_d = 4'd0;
                end
            end
            StDma: begin
                bus.m_addr  = dma_word;
                bus.m_we    = we_q;
                bus.m_wdata = bus.d_wdata;
                bus.d_ack   = 1'b1;
                bus.p_stall = bus.p_req;
                if (beat_q == len_q - 4'd1) begin
                    bus.d_done = 1'b1;
                    state_d    = StIdle;
                    beat_d     = 4'd0;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= StIdle;
            beat_q   <= 4'd0;
            len_q    <= 4'd1;
            starve_q <= 4'd0;
            base_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            starve_q <= starve_d;
            base_q   <= base_d;
            we_q     <= we_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table with a queue of expected
// outputs, plus hand-written starvation and mid-burst reset sequences.
module tb_dmem_arbiter;
    localparam int unsigned AW = 5;

    typedef struct {
        logic        pr, pw;
        logic [31:0] pa, pd;
        logic        dr, dw;
        logic [31:0] db;
        logic [3:0]  dl;
        logic [31:0] dd;
        logic        es, ea, ed, ew;
        logic [4:0]  eaddr;
        logic [1:0]  rsel;
        logic [31:0] erd;
    } vec_t;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        ram_init = 1'b0;
    logic [31:0] ram [32];
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tab [26];
    vec_t        exp_q [$];

    dmem_arbiter_if #(.AW(AW)) bus ();

    dmem_arbiter #(.AW(AW), .BURST_MAX(8), .STARVE_LIM(4)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Bench-side RAM: combinational read, write on rising edge.
    assign bus.m_rdata = ram[bus.m_addr];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 32; i++) ram[i] <= 32'hA000_0000 | 32'(i);
        end else if (bus.m_we) begin
            ram[bus.m_addr] <= bus.m_wdata;
        end
    end

    function automatic vec_t mk(logic [31:0] pr, pw, pa, pd, dr, dw, db, dl, dd,
                                logic [31:0] es, ea, ed, ew, eaddr, rsel, erd);
        vec_t v;
        v.pr = pr[0]; v.pw = pw[0]; v.pa = pa; v.pd = pd;
        v.dr = dr[0]; v.dw = dw[0]; v.db = db; v.dl = dl[3:0]; v.dd = dd;
        v.es = es[0]; v.ea = ea[0]; v.ed = ed[0]; v.ew = ew[0];
        v.eaddr = eaddr[4:0]; v.rsel = rsel[1:0]; v.erd = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.p_req = v.pr; bus.p_we = v.pw; bus.p_addr = v.pa; bus.p_wdata = v.pd;
        bus.d_req = v.dr; bus.d_we = v.dw; bus.d_base = v.db; bus.d_len = v.dl;
        bus.d_wdata = v.dd;
    endtask

    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, " p_stall"}, 32'(bus.p_stall), 32'(e.es));
        chk({tag, " d_ack"},   32'(bus.d_ack),   32'(e.ea));
        chk({tag, " d_done"},  32'(bus.d_done),  32'(e.ed));
        chk({tag, " m_we"},    32'(bus.m_we),    32'(e.ew));
        chk({tag, " m_addr"},  32'(bus.m_addr),  32'(e.eaddr));
        if (e.rsel == 2'd1) chk({tag, " p_rdata"}, bus.p_rdata, e.erd);
        if (e.rsel == 2'd2) chk({tag, " d_rdata"}, bus.d_rdata, e.erd);
    endtask

    initial begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        ram_init = 1'b1;
        @(posedge clk);
        #1 ram_init = 1'b0;
        chk("reset d_ack", 32'(bus.d_ack), 0);
        chk("reset d_done", 32'(bus.d_done), 0);
        chk("reset p_stall", 32'(bus.p_stall), 0);
        chk("reset m_we", 32'(bus.m_we), 0);
        @(negedge clk);
        clrn = 1'b1;

        //         pr pw pa     pd     dr dw db     dl dd      es ea ed ew addr rs erd
        tab[0]  = mk(0, 0, 0,     0,     0, 0, 0,     0, 0,      0, 0, 0, 0, 0,  0, 0);
        tab[1]  = mk(1, 1, 'h0C,  'hAA,  0, 0, 0,     0, 0,      0, 0, 0, 1, 3,  0, 0);
        tab[2]  = mk(1, 0, 'h0C,  0,     0, 0, 0,     0, 0,      0, 0, 0, 0, 3,  1, 'hAA);
        tab[3]  = mk(0, 0, 0,     0,     1, 1, 'h10,  3, 0,      0, 0, 0, 0, 0,  0, 0);
        tab[4]  = mk(0, 0, 0,     0,     0, 0, 0,     0, 'h11,   0, 1, 0, 1, 4,  0, 0);
        tab[5]  = mk(1, 1, 'h7C,  'hDEAD, 0, 0, 0,    0, 'h22,   1, 1, 0, 1, 5,  0, 0);
        tab[6]  = mk(0, 0, 0,     0,     0, 0, 0,     0, 'h33,   0, 1, 1, 1, 6,  0, 0);
        tab[7]  = mk(1, 0, 'h14,  0,     0, 0, 0,     0, 0,      0, 0, 0, 0, 5,  1, 'h22);
        tab[8]  = mk(0, 0, 0,     0,     1, 0, 'h78,  4, 0,      0, 0, 0, 0, 0,  0, 0);
        tab[9]  = mk(0, 0, 0,     0,     0, 0, 0,     0, 0,      0, 1, 0, 0, 30, 2, 'hA000_001E);
        tab[10] = mk(0, 0, 0,     0,     0, 0, 0,     0, 0,      0, 1, 0, 0, 31, 2, 'hA000_001F);
        tab[11] = mk(0, 0, 0,     0,     0, 0, 0,     0, 0,      0, 1, 0, 0, 0,  2, 'hA000_0000);
        tab[12] = mk(0, 0, 0,     0,     0, 0, 0,     0, 0,      0, 1, 1, 0, 1,  2, 'hA000_0001);
        tab[13] = mk(0, 0, 0,     0,     1, 0, 0,     0, 0,      0, 0, 0, 0, 0,  0, 0);
        tab[14] = mk(0, 0, 0,     0,     0, 0, 0,     0, 0,      0, 1, 1, 0, 0,  2, 'hA000_0000);
        tab[15] = mk(0, 0, 0,     0,     0, 0, 0,     0, 0,      0, 0, 0, 0, 0,  0, 0);
        tab[16] = mk(0, 0, 0,     0,     1, 0, 'h40,  12, 0,     0, 0, 0, 0, 0,  0, 0);
        for (int k = 0; k < 8; k++) begin
            tab[17+k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(k == 7), 0, 32'(16 + k), 2,
                           32'hA000_0010 + 32'(k));
        end
        tab[25] = mk(0, 0, 0,     0,     0, 0, 0,     0, 0,      0, 0, 0, 0, 0,  0, 0);

        for (int i = 0; i < 26; i++) apply($sformatf("v%0d", i), tab[i]);
        chk("ram[4]", ram[4], 32'h11);
        chk("ram[5]", ram[5], 32'h22);
        chk("ram[6]", ram[6], 32'h33);
        chk("ram[31] untouched", ram[31], 32'hA000_001F);

        // Starvation: pipeline busy every cycle, DMA forced through after STARVE_LIM.
        for (int c = 0; c < 8; c++) begin
            apply($sformatf("starve c%0d", c),
                  mk(1, 0, 0, 0, 32'(c <= 4), 1, 'h20, 2, 32'h5A00 + 32'(c),
                     32'(c == 5 || c == 6), 32'(c == 5 || c == 6), 32'(c == 6),
                     32'(c == 5 || c == 6), (c == 5) ? 8 : (c == 6) ? 9 : 0, 0, 0));
        end
        chk("ram[8]", ram[8], 32'h5A05);
        chk("ram[9]", ram[9], 32'h5A06);

        // Reset pulse in the third beat of a 5-beat write burst.
        apply("rst req",   mk(0, 0, 0, 0, 1, 1, 'h60, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("rst beat0", mk(0, 0, 0, 0, 0, 0, 0, 0, 'h7700_0000, 0, 1, 0, 1, 24, 0, 0));
        apply("rst beat1", mk(0, 0, 0, 0, 0, 0, 0, 0, 'h7700_0001, 0, 1, 0, 1, 25, 0, 0));
        @(posedge clk);
        #1 bus.d_wdata = 32'h7700_0002;
        #1 chk("rst beat2 d_ack", 32'(bus.d_ack), 1);
        chk("rst beat2 m_addr", 32'(bus.m_addr), 26);
        #1 clrn = 1'b0;
        #1 chk("rst in d_ack", 32'(bus.d_ack), 0);
        chk("rst in d_done", 32'(bus.d_done), 0);
        chk("rst in m_we", 32'(bus.m_we), 0);
        #1 clrn = 1'b1;
        apply("rst after", mk(0, 0, 0, 0, 0, 0, 0, 0, 'h7700_0003, 0, 0, 0, 0, 0, 0, 0));
        apply("rst after2", mk(1, 0, 'h68, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 26, 1, 'hA000_001A));
        chk("ram[24]", ram[24], 32'h7700_0000);
        chk("ram[25]", ram[25], 32'h7700_0001);
        chk("ram[26]", ram[26], 32'hA000_001A);
        chk("ram[27]", ram[27], 32'hA000_001B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
